// File: rtl/tejas_pkg.sv
// rtl/tejas_pkg.sv - shared core constants for the writeback path
//
// Purpose: datapath width, register address width and the fixed
//          writeback requester indices used by the register file arbiter.
// Ports:   none (package).
package tejas_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   // Writeback requester slots; the index is also the arbiter port number.
   localparam int WB_ALU = 0;
   localparam int WB_LSU = 1;
   localparam int WB_CSR = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin one-hot grant
//
// Purpose: picks the first asserted request at or after ptr, wrapping
//          modulo NREQ. Holds no state; the pointer register lives in the
//          parent.
// Ports:   req [NREQ]  - request vector
//          ptr [PTR_W] - index that has highest priority this cycle
//          gnt [NREQ]  - one-hot grant, all-zero when req is all-zero
module rr_arbiter #(
   parameter  int NREQ  = 3,
   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt
);

   logic [NREQ-1:0] mask;
   logic [NREQ-1:0] req_hi;

   // Requests at or above ptr are searched first; if none exist the search
   // wraps to the lowest-indexed request overall. x & (~x + 1) isolates the
   // lowest set bit.
   always_comb begin
      mask = '0;
      for (int i = 0; i < NREQ; i++) begin
         mask[i] = (PTR_W'(i) >= ptr);
      end
      req_hi = req & mask;
      if (|req_hi) begin
         gnt = req_hi & (~req_hi + NREQ'(1));
      end else begin
         gnt = req & (~req + NREQ'(1));
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter for the register file write port
//
// Purpose: shares the single register file write port among NREQ writeback
//          requesters (0 = ALU, 1 = LSU, 2 = CSR). The winner of each cycle
//          is registered into one output stage that drives the write port on
//          the following cycle. Writes to x0 complete their handshake but are
//          never written.
// Config:  WB_ARB_FWD_EN - adds two read ports that bypass the staged write
//          to readers in the cycle it is being written.
// Ports:   clock, resetn           - clock, asynchronous active-low reset
//          req_valid [NREQ]        - requester i holds a write
//          req_rd    [NREQ*5]      - destination per requester, i at [5i+4:5i]
//          req_data  [NREQ*XLEN]   - write data per requester, packed likewise
//          req_ready [NREQ]        - one-hot grant
//          rf_we, rf_rd_addr, rf_rd_data - register file write port
//          busy                    - output stage holds a valid write
//          fwd_rsK_addr/in/out     - forwarding read ports (WB_ARB_FWD_EN only)
module regfile_wb_arbiter
   import tejas_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int XLEN = tejas_pkg::XLEN
) (
   input  logic                         clock,
   input  logic                         resetn,
   input  logic [NREQ-1:0]              req_valid,
   input  logic [NREQ*REG_ADDR_W-1:0]   req_rd,
   input  logic [NREQ*XLEN-1:0]         req_data,
   output logic [NREQ-1:0]              req_ready,
   output logic                         rf_we,
   output logic [REG_ADDR_W-1:0]        rf_rd_addr,
   output logic [XLEN-1:0]              rf_rd_data,
   output logic                         busy
`ifdef WB_ARB_FWD_EN
   ,
   input  logic [REG_ADDR_W-1:0]        fwd_rs1_addr,
   input  logic [REG_ADDR_W-1:0]        fwd_rs2_addr,
   input  logic [XLEN-1:0]              fwd_rs1_in,
   input  logic [XLEN-1:0]              fwd_rs2_in,
   output logic [XLEN-1:0]              fwd_rs1_out,
   output logic [XLEN-1:0]              fwd_rs2_out
`endif
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic                  stg_valid_q, stg_valid_d;
   logic [REG_ADDR_W-1:0] stg_rd_q, stg_rd_d;
   logic [XLEN-1:0]       stg_data_q, stg_data_d;

   logic [NREQ-1:0]       gnt;
   logic                  any_gnt;
   logic [PTR_W-1:0]      gnt_idx;
   logic [REG_ADDR_W-1:0] sel_rd;
   logic [XLEN-1:0]       sel_data;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_rr_arbiter (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (gnt)
   );

   assign req_ready = gnt;

   // gnt is one-hot, so a last-match loop is an exact select.
   always_comb begin
      any_gnt  = |gnt;
      gnt_idx  = '0;
      sel_rd   = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            gnt_idx  = PTR_W'(i);
            sel_rd   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
            sel_data = req_data[i*XLEN +: XLEN];
         end
      end
   end

   // The register file never back-pressures, so the stage is refilled (or
   // emptied) every cycle. Payload is held when idle to avoid needless toggling.
   always_comb begin
      ptr_d       = ptr_q;
      stg_valid_d = any_gnt;
      stg_rd_d    = stg_rd_q;
      stg_data_d  = stg_data_q;
      if (any_gnt) begin
         ptr_d      = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
         stg_rd_d   = sel_rd;
         stg_data_d = sel_data;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ptr_q       <= '0;
         stg_valid_q <= 1'b0;
         stg_rd_q    <= '0;
         stg_data_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         stg_valid_q <= stg_valid_d;
         stg_rd_q    <= stg_rd_d;
         stg_data_q  <= stg_data_d;
      end
   end

   // x0 is hardwired zero: the write is consumed but suppressed here.
   assign rf_we      = stg_valid_q & (stg_rd_q != '0);
   assign rf_rd_addr = stg_rd_q;
   assign rf_rd_data = stg_data_q;
   assign busy       = stg_valid_q;

`ifdef WB_ARB_FWD_EN
   // Bypass the staged write to readers during the cycle it is written.
   always_comb begin
      fwd_rs1_out = fwd_rs1_in;
      fwd_rs2_out = fwd_rs2_in;
      if (rf_we && (stg_rd_q == fwd_rs1_addr)) begin
         fwd_rs1_out = stg_data_q;
      end
      if (rf_we && (stg_rd_q == fwd_rs2_addr)) begin
         fwd_rs2_out = stg_data_q;
      end
   end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed table-driven bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

   logic        clock;
   logic        resetn;
   logic [2:0]  req_valid;
   logic [14:0] req_rd;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        rf_we;
   logic [4:0]  rf_rd_addr;
   logic [31:0] rf_rd_data;
   logic        busy;
`ifdef WB_ARB_FWD_EN
   logic [4:0]  fwd_rs1_addr, fwd_rs2_addr;
   logic [31:0] fwd_rs1_in, fwd_rs2_in, fwd_rs1_out, fwd_rs2_out;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   regfile_wb_arbiter #(
      .NREQ (3),
      .XLEN (32)
   ) dut (
      .clock      (clock),
      .resetn     (resetn),
      .req_valid  (req_valid),
      .req_rd     (req_rd),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .rf_we      (rf_we),
      .rf_rd_addr (rf_rd_addr),
      .rf_rd_data (rf_rd_data),
      .busy       (busy)
`ifdef WB_ARB_FWD_EN
      ,
      .fwd_rs1_addr (fwd_rs1_addr),
      .fwd_rs2_addr (fwd_rs2_addr),
      .fwd_rs1_in   (fwd_rs1_in),
      .fwd_rs2_in   (fwd_rs2_in),
      .fwd_rs1_out  (fwd_rs1_out),
      .fwd_rs2_out  (fwd_rs2_out)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [2:0]  valid;
      logic [14:0] rd;
      logic [95:0] data;
      logic [2:0]  exp_ready;
      logic        exp_we;
      logic        exp_busy;
      logic        chk_pay;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] v, input logic [14:0] r, input logic [95:0] d);
      req_valid = v;
      req_rd    = r;
      req_data  = d;
   endtask

   localparam logic [14:0] RA = {5'd3, 5'd2, 5'd1};
   localparam logic [95:0] DA = {32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
   localparam logic [14:0] RB = {5'd0, 5'd0, 5'd5};
   localparam logic [95:0] DB = {32'h0, 32'h0, 32'hDEADBEEF};
   localparam logic [14:0] RC = {5'd0, 5'd0, 5'd0};
   localparam logic [95:0] DC = {32'h0, 32'h00001234, 32'h0};
   localparam logic [14:0] RD = {5'd9, 5'd0, 5'd9};
   localparam logic [95:0] DD = {32'h22222222, 32'h0, 32'h11111111};
   localparam logic [14:0] RE = {5'd6, 5'd5, 5'd4};
   localparam logic [95:0] DE = {32'h60606060, 32'h50505050, 32'h40404040};

   initial begin
      // valid, rd, data, exp_ready, exp_we, exp_busy, chk_pay, exp_addr, exp_data
      // rf_* expectations are the stage contents loaded by the previous row.
      vecs[0]  = '{3'b111, RA, DA, 3'b001, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0};
      vecs[1]  = '{3'b110, RA, DA, 3'b010, 1'b1, 1'b1, 1'b1, 5'd1, 32'hA0A0A0A0};
      vecs[2]  = '{3'b101, RA, DA, 3'b100, 1'b1, 1'b1, 1'b1, 5'd2, 32'hB1B1B1B1};
      vecs[3]  = '{3'b011, RA, DA, 3'b001, 1'b1, 1'b1, 1'b1, 5'd3, 32'hC2C2C2C2};
      vecs[4]  = '{3'b110, RA, DA, 3'b010, 1'b1, 1'b1, 1'b1, 5'd1, 32'hA0A0A0A0};
      vecs[5]  = '{3'b101, RA, DA, 3'b100, 1'b1, 1'b1, 1'b1, 5'd2, 32'hB1B1B1B1};
      vecs[6]  = '{3'b000, RA, DA, 3'b000, 1'b1, 1'b1, 1'b1, 5'd3, 32'hC2C2C2C2};
      vecs[7]  = '{3'b000, RA, DA, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
      vecs[8]  = '{3'b001, RB, DB, 3'b001, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
      vecs[9]  = '{3'b000, RB, DB, 3'b000, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF};
      vecs[10] = '{3'b010, RC, DC, 3'b010, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
      vecs[11] = '{3'b000, RC, DC, 3'b000, 1'b0, 1'b1, 1'b1, 5'd0, 32'h00001234};
      vecs[12] = '{3'b101, RD, DD, 3'b100, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
      vecs[13] = '{3'b001, RD, DD, 3'b001, 1'b1, 1'b1, 1'b1, 5'd9, 32'h22222222};
      vecs[14] = '{3'b000, RD, DD, 3'b000, 1'b1, 1'b1, 1'b1, 5'd9, 32'h11111111};
      vecs[15] = '{3'b111, RE, DE, 3'b010, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
      vecs[16] = '{3'b111, RE, DE, 3'b100, 1'b1, 1'b1, 1'b1, 5'd5, 32'h50505050};
      vecs[17] = '{3'b111, RE, DE, 3'b001, 1'b1, 1'b1, 1'b1, 5'd6, 32'h60606060};
      vecs[18] = '{3'b000, RE, DE, 3'b000, 1'b1, 1'b1, 1'b1, 5'd4, 32'h40404040};

`ifdef WB_ARB_FWD_EN
      fwd_rs1_addr = '0; fwd_rs2_addr = '0; fwd_rs1_in = '0; fwd_rs2_in = '0;
`endif

      // Reset held with all requesters valid.
      resetn = 1'b0;
      drive(3'b111, RA, DA);
      repeat (3) begin
         @(negedge clock);
         #1;
         check("reset_we", 32'(rf_we), 32'h0);
         check("reset_busy", 32'(busy), 32'h0);
      end

      // Vector table; row 0 is the first cycle after release.
      for (int k = 0; k < 19; k++) begin
         @(negedge clock);
         resetn = 1'b1;
         drive(vecs[k].valid, vecs[k].rd, vecs[k].data);
         #1;
         check($sformatf("v%0d_ready", k), 32'(req_ready), 32'(vecs[k].exp_ready));
         check($sformatf("v%0d_we", k), 32'(rf_we), 32'(vecs[k].exp_we));
         check($sformatf("v%0d_busy", k), 32'(busy), 32'(vecs[k].exp_busy));
         if (vecs[k].chk_pay) begin
            check($sformatf("v%0d_addr", k), 32'(rf_rd_addr), 32'(vecs[k].exp_addr));
            check($sformatf("v%0d_data", k), rf_rd_data, vecs[k].exp_data);
         end
      end

      // Reset mid-write: ptr is 1 here, so index 0 wins only by wrapping.
      @(negedge clock);
      drive(3'b001, {5'd0, 5'd0, 5'd3}, {32'h0, 32'h0, 32'h33333333});
      #1;
      check("midrst_ready_wrap", 32'(req_ready), 32'h1);
      @(negedge clock);
      drive(3'b000, RA, DA);
      #1;
      check("midrst_we_before", 32'(rf_we), 32'h1);
      check("midrst_addr_before", 32'(rf_rd_addr), 32'h3);
      resetn = 1'b0;
      #1;
      check("midrst_we_drop", 32'(rf_we), 32'h0);
      check("midrst_busy_drop", 32'(busy), 32'h0);
      check("midrst_addr_clr", 32'(rf_rd_addr), 32'h0);
      @(negedge clock);
      #1;
      check("midrst_we_held", 32'(rf_we), 32'h0);
      @(negedge clock);
      resetn = 1'b1;
      drive(3'b111, RA, DA);
      #1;
      check("midrst_ptr_zero", 32'(req_ready), 32'h1);
      @(negedge clock);
      drive(3'b000, RA, DA);
      #1;
      check("postrst_we", 32'(rf_we), 32'h1);
      check("postrst_data", rf_rd_data, 32'hA0A0A0A0);

`ifdef WB_ARB_FWD_EN
      @(negedge clock);
      drive(3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'hA5A5A5A5});
      @(negedge clock);
      drive(3'b000, RA, DA);
      fwd_rs1_addr = 5'd7; fwd_rs1_in = 32'h0;
      fwd_rs2_addr = 5'd0; fwd_rs2_in = 32'h0BADF00D;
      #1;
      check("fwd_rs1_hit", fwd_rs1_out, 32'hA5A5A5A5);
      check("fwd_rs2_x0", fwd_rs2_out, 32'h0BADF00D);
`endif

      @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
